// File: rtl/mem_access_ctrl_if.sv
// Word-wide memory bus between mem_access_ctrl (master) and the data memory (slave).
// Request/acknowledge handshake: one mem_ack completes one transaction.
interface mem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: word-aligned bus accesses, zero-extended sub-word loads,
// read-modify-write sub-word stores. Define MISALIGN_CHK_EN to reject misaligned word/half.
module mem_access_ctrl (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req,
   input  logic                     i_we,
   input  logic [1:0]               i_size,
   input  logic [31:0]              i_addr,
   input  logic [31:0]              i_wdata,
   mem_access_ctrl_if.master        mem,
   output logic [31:0]              o_rdata,
   output logic                     o_done,
   output logic                     o_busy,
   output logic                     o_err
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_merge;
   logic [31:0] r_rdata;

   logic        w_req_word;
   logic        w_misalign;
   logic        w_sub_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign w_req_word = (i_size != SZ_BYTE) && (i_size != SZ_HALF);
   assign w_sub_word = (r_size == SZ_BYTE) || (r_size == SZ_HALF);

`ifdef MISALIGN_CHK_EN
   logic r_err;
   assign w_misalign = (w_req_word && (i_addr[1:0] != 2'b00)) ||
                       ((i_size == SZ_HALF) && i_addr[0]);
   assign o_err      = (r_state == S_DONE) && r_err;
`else
   assign w_misalign = 1'b0;
   assign o_err      = 1'b0;
`endif

   // Lane selection on the read word; shared by load extraction and store merge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      w_byte   = mem.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_half   = r_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      w_load   = mem.mem_rdata;
      w_merged = mem.mem_rdata;
      case (r_size)
         SZ_BYTE: begin
            w_load = {24'b0, w_byte};
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
         end
         SZ_HALF: begin
            w_load = {16'b0, w_half};
            if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
         end
         default: begin
            w_load   = mem.mem_rdata;
            w_merged = r_wdata;
         end
      endcase
   end

   always_comb begin
      w_next        = r_state;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      o_done        = 1'b0;
      o_busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_req) begin
               if (w_misalign)              w_next = S_DONE;
               else if (i_we && w_req_word) w_next = S_WR;
               else                         w_next = S_RD;
            end
         end
         S_RD: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ack) w_next = r_we ? S_WR : S_DONE;
         end
         S_WR: begin
            mem.mem_req = 1'b1;
            mem.mem_we  = 1'b1;
            if (mem.mem_ack) w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign mem.mem_addr  = {r_addr[31:2], 2'b00};
   assign mem.mem_wdata = w_sub_word ? r_merge : r_wdata;
   assign o_rdata       = r_rdata;

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_rst) begin
         // NOTE: the merge buffer is a plain register, so it is reset along with everything else.
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_merge <= 32'd0;
         r_rdata <= 32'd0;
`ifdef MISALIGN_CHK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && i_req) begin
            r_we    <= i_we;
            r_size  <= i_size;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
`ifdef MISALIGN_CHK_EN
            r_err   <= w_misalign;
`endif
         end
         // Loads update the result; sub-word stores capture the merged word for WR.
         if (r_state == S_RD && mem.mem_ack) begin
            if (r_we) r_merge <= w_merged;
            else      r_rdata <= w_load;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, sub-word RMW stores, wait states,
// held request, reset mid-transaction and the optional misalignment check.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        busy;
   logic        err;

   int n_vec  = 0;
   int n_miss = 0;

   mem_access_ctrl_if bus ();

   mem_access_ctrl dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_we    (we),
      .i_size  (size),
      .i_addr  (addr),
      .i_wdata (wdata),
      .mem     (bus.master),
      .o_rdata (rdata),
      .o_done  (done),
      .o_busy  (busy),
      .o_err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "/req"},  32'(bus.mem_req), 32'd0);
      check({tag, "/busy"}, 32'(busy),        32'd0);
      check({tag, "/done"}, 32'(done),        32'd0);
   endtask

   // One full access with directed ack delays. exp_val is the load result for loads and
   // the word written to memory for stores; exp_addr is the word address on the bus.
   task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] mem_word, input int rd_waits,
                            input int wr_waits, input logic [31:0] exp_addr,
                            input logic [31:0] exp_val);
      logic sub;
      sub   = (sz == 2'd1) || (sz == 2'd2);
      req   = 1'b1;
      we    = w;
      size  = sz;
      addr  = a;
      wdata = wd;
      tick();
      req = 1'b0;
      check({tag, "/addr"}, bus.mem_addr,  exp_addr);
      check({tag, "/busy"}, 32'(busy),     32'd1);
      if (!w || sub) begin
         check({tag, "/rd_req"}, 32'(bus.mem_req), 32'd1);
         check({tag, "/rd_we"},  32'(bus.mem_we),  32'd0);
         for (int i = 0; i < rd_waits; i++) begin
            tick();
            check({tag, "/rd_hold"}, 32'(bus.mem_req), 32'd1);
            check({tag, "/rd_addr"}, bus.mem_addr,     exp_addr);
            check({tag, "/rd_done"}, 32'(done),        32'd0);
         end
         bus.mem_rdata = mem_word;
         bus.mem_ack   = 1'b1;
         tick();
         bus.mem_ack   = 1'b0;
      end
      if (w) begin
         check({tag, "/wr_req"},   32'(bus.mem_req), 32'd1);
         check({tag, "/wr_we"},    32'(bus.mem_we),  32'd1);
         check({tag, "/wr_data"},  bus.mem_wdata,    exp_val);
         for (int i = 0; i < wr_waits; i++) begin
            tick();
            check({tag, "/wr_hold"}, bus.mem_wdata, exp_val);
            check({tag, "/wr_done"}, 32'(done),     32'd0);
         end
         bus.mem_ack = 1'b1;
         tick();
         bus.mem_ack = 1'b0;
      end
      check({tag, "/done"},   32'(done),        32'd1);
      check({tag, "/err"},    32'(err),         32'd0);
      check({tag, "/dn_req"}, 32'(bus.mem_req), 32'd0);
      if (!w) check({tag, "/rdata"}, rdata, exp_val);
      tick();
      check_idle({tag, "/after"});
   endtask

   initial begin
      rst           = 1'b1;
      req           = 1'b0;
      we            = 1'b0;
      size          = 2'd0;
      addr          = 32'd0;
      wdata         = 32'd0;
      bus.mem_rdata = 32'd0;
      bus.mem_ack   = 1'b0;
      tick();
      tick();
      check_idle("reset");
      check("reset/we",    32'(bus.mem_we), 32'd0);
      check("reset/err",   32'(err),        32'd0);
      check("reset/addr",  bus.mem_addr,    32'd0);
      check("reset/wdata", bus.mem_wdata,   32'd0);
      check("reset/rdata", rdata,           32'd0);
      rst = 1'b0;
      tick();

      // Loads: word, byte lane 3, upper half, byte lane 0 with one wait state.
      do_access("ld_w",  1'b0, 2'd0, 32'h10, 32'h0, 32'hA1B2C3D4, 0, 0, 32'h10, 32'hA1B2C3D4);
      do_access("ld_b3", 1'b0, 2'd1, 32'h13, 32'h0, 32'hA1B2C3D4, 0, 0, 32'h10, 32'h000000A1);
      do_access("ld_h1", 1'b0, 2'd2, 32'h12, 32'h0, 32'hA1B2C3D4, 0, 0, 32'h10, 32'h0000A1B2);
      do_access("ld_b0", 1'b0, 2'd1, 32'h10, 32'h0, 32'hA1B2C3D4, 1, 0, 32'h10, 32'h000000D4);
      do_access("ld_s3", 1'b0, 2'd3, 32'h18, 32'h0, 32'h0BADF00D, 0, 0, 32'h18, 32'h0BADF00D);

      // Sub-word stores: read-modify-write, other lanes keep memory contents.
      do_access("st_b1", 1'b1, 2'd1, 32'h21, 32'h000000EE, 32'h11223344, 2, 2, 32'h20, 32'h1122EE44);
      check("st_b1/rdata_kept", rdata, 32'h0BADF00D);
      do_access("st_h1", 1'b1, 2'd2, 32'h26, 32'h0000BEEF, 32'h11223344, 0, 0, 32'h24, 32'hBEEF3344);
      do_access("st_b3", 1'b1, 2'd1, 32'h2B, 32'hFFFFFF5A, 32'h11223344, 0, 1, 32'h28, 32'h5A223344);

      // Word store with req held high and wdata changing: one write, no queued restart.
      req   = 1'b1;
      we    = 1'b1;
      size  = 2'd0;
      addr  = 32'h40;
      wdata = 32'hCAFEF00D;
      tick();
      wdata = 32'h12345678;
      check("hold/we",    32'(bus.mem_we), 32'd1);
      check("hold/addr",  bus.mem_addr,    32'h40);
      check("hold/wdata", bus.mem_wdata,   32'hCAFEF00D);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold/wait_we",    32'(bus.mem_we), 32'd1);
         check("hold/wait_wdata", bus.mem_wdata,   32'hCAFEF00D);
         check("hold/wait_done",  32'(done),       32'd0);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("hold/done",     32'(done),        32'd1);
      check("hold/dn_req",   32'(bus.mem_req), 32'd0);
      tick();
      check("hold/idle_dn",  32'(done),        32'd0);
      check("hold/idle_bsy", 32'(busy),        32'd0);
      tick();
      req = 1'b0;
      check("hold/again_we",    32'(bus.mem_we), 32'd1);
      check("hold/again_wdata", bus.mem_wdata,   32'h12345678);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("hold/again_done", 32'(done), 32'd1);
      tick();
      check_idle("hold/end");

      // Reset during a WR wait with an ack pending in the same cycle.
      req   = 1'b1;
      we    = 1'b1;
      size  = 2'd0;
      addr  = 32'h50;
      wdata = 32'h77777777;
      tick();
      req = 1'b0;
      tick();
      check("rst_wr/we", 32'(bus.mem_we), 32'd1);
      rst         = 1'b1;
      bus.mem_ack = 1'b1;
      tick();
      rst         = 1'b0;
      bus.mem_ack = 1'b0;
      check_idle("rst_wr");
      check("rst_wr/addr",  bus.mem_addr, 32'd0);
      check("rst_wr/rdata", rdata,        32'd0);
      tick();
      check("rst_wr/no_done", 32'(done), 32'd0);
      do_access("rst_ld", 1'b0, 2'd0, 32'h14, 32'h0, 32'hDEADBEEF, 0, 0, 32'h14, 32'hDEADBEEF);

      // Ack while idle is ignored.
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check_idle("idle_ack");
      check("idle_ack/rdata", rdata, 32'hDEADBEEF);

`ifdef MISALIGN_CHK_EN
      req  = 1'b1;
      we   = 1'b0;
      size = 2'd0;
      addr = 32'h22;
      tick();
      req = 1'b0;
      check("mis/req",   32'(bus.mem_req), 32'd0);
      check("mis/done",  32'(done),        32'd1);
      check("mis/err",   32'(err),         32'd1);
      check("mis/rdata", rdata,            32'hDEADBEEF);
      tick();
      check_idle("mis/after");
      check("mis/err_clr", 32'(err), 32'd0);
`else
      do_access("mis", 1'b0, 2'd0, 32'h22, 32'h0, 32'h55667788, 0, 0, 32'h20, 32'h55667788);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
